// File: rtl/qam_pkg.sv
// Shared QAM demod types and widths for the demult / defilter / scheduler slice.
package qam_pkg;

  localparam int unsigned QAM_DIN_W  = 24;
  localparam int unsigned QAM_DOUT_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND_I = 2'd1,
    SEND_Q = 2'd2
  } defir_sched_st_t;

  typedef enum logic {
    PAR_I = 1'b0,
    PAR_Q = 1'b1
  } iq_parity_t;

endpackage

// File: rtl/qam_iq_reassembler.sv
// Re-pairs the serialised I-then-Q stream coming back from the shared FIR.
// Beats arriving with nothing outstanding are dropped and flagged as orphans.
module qam_iq_reassembler
  import qam_pkg::*;
#(
  parameter int unsigned DOUT_W = QAM_DOUT_W
) (
  input  logic              axi_clk,
  input  logic              axi_rst,
  input  logic              fir_m_tvalid,
  input  logic [DOUT_W-1:0] fir_m_tdata,
  input  logic              outst_zero,
  output logic              m_valid,
  output logic [DOUT_W-1:0] m_i,
  output logic [DOUT_W-1:0] m_q,
  output logic              orphan
);

  iq_parity_t        parity;
  logic [DOUT_W-1:0] hold_i;
  logic              beat;

  assign beat = fir_m_tvalid & ~outst_zero;

  // Parity tracks which rail the next legitimate beat belongs to.
  always_ff @(posedge axi_clk) begin
    if (axi_rst) begin
      parity  <= PAR_I;
      hold_i  <= '0;
      m_valid <= 1'b0;
      m_i     <= '0;
      m_q     <= '0;
      orphan  <= 1'b0;
    end else begin
      m_valid <= 1'b0;
      if (fir_m_tvalid && outst_zero) begin
        orphan <= 1'b1;
      end
      if (beat) begin
        if (parity == PAR_I) begin
          hold_i <= fir_m_tdata;
          parity <= PAR_Q;
        end else begin
          m_i     <= hold_i;
          m_q     <= fir_m_tdata;
          m_valid <= 1'b1;
          parity  <= PAR_I;
        end
      end
    end
  end

endmodule

// File: rtl/qam_defir_scheduler.sv
// Time-shares one demod FIR between the I and Q rails: serialises each pair
// as I-then-Q beats, bounds beats in flight and re-pairs the filtered results.
module qam_defir_scheduler
  import qam_pkg::*;
#(
  parameter int unsigned DIN_W     = QAM_DIN_W,
  parameter int unsigned DOUT_W    = QAM_DOUT_W,
  parameter int unsigned MAX_OUTST = 32,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              axi_clk,
  input  logic              axi_rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DIN_W-1:0]  s_i,
  input  logic [DIN_W-1:0]  s_q,
  output logic              fir_s_tvalid,
  input  logic              fir_s_tready,
  output logic [DIN_W-1:0]  fir_s_tdata,
  input  logic              fir_m_tvalid,
  input  logic [DOUT_W-1:0] fir_m_tdata,
  output logic              m_valid,
  output logic [DOUT_W-1:0] m_i,
  output logic [DOUT_W-1:0] m_q,
  output logic              overrun,
  output logic [CNT_W-1:0]  drop_cnt,
  output logic              orphan
);

  localparam int unsigned     OUT_W   = $clog2(MAX_OUTST + 1);
  localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_OUTST);

  defir_sched_st_t  state, state_n;
  logic [OUT_W-1:0] outst, outst_n;
  logic [DIN_W-1:0] hold_q, hold_q_n;
  logic [DIN_W-1:0] tdata_n;
  logic             s_ready_n;
  logic             tvalid_n;
  logic             overrun_n;
  logic [CNT_W-1:0] drop_cnt_n;
  logic             fir_in_fire;
  logic             fir_out_beat;

  always_ff @(posedge axi_clk) begin
    if (axi_rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Outputs are precomputed from the next state so they leave the block registered.
  always_comb begin
    state_n      = state;
    hold_q_n     = hold_q;
    tdata_n      = fir_s_tdata;
    overrun_n    = overrun;
    drop_cnt_n   = drop_cnt;
    outst_n      = outst;
    fir_in_fire  = fir_s_tvalid & fir_s_tready;
    fir_out_beat = fir_m_tvalid & (outst != '0);

    case (state)
      IDLE: begin
        if (s_valid) begin
          state_n  = SEND_I;
          tdata_n  = s_i;
          hold_q_n = s_q;
        end
      end
      SEND_I: begin
        if (fir_in_fire) begin
          state_n = SEND_Q;
          tdata_n = hold_q;
        end
      end
      SEND_Q: begin
        if (fir_in_fire) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    if (s_valid && !s_ready) begin
      overrun_n = 1'b1;
      if (drop_cnt != '1) begin
        drop_cnt_n = drop_cnt + CNT_W'(1);
      end
    end

    if (fir_in_fire && !fir_out_beat) begin
      outst_n = outst + OUT_W'(1);
    end else if (!fir_in_fire && fir_out_beat) begin
      outst_n = outst - OUT_W'(1);
    end

    s_ready_n = (state_n == IDLE);
    tvalid_n  = (state_n != IDLE) && (outst_n != OUT_MAX);
  end

  always_ff @(posedge axi_clk) begin
    if (axi_rst) begin
      outst        <= '0;
      hold_q       <= '0;
      fir_s_tdata  <= '0;
      fir_s_tvalid <= 1'b0;
      s_ready      <= 1'b1;
      overrun      <= 1'b0;
      drop_cnt     <= '0;
    end else begin
      outst        <= outst_n;
      hold_q       <= hold_q_n;
      fir_s_tdata  <= tdata_n;
      fir_s_tvalid <= tvalid_n;
      s_ready      <= s_ready_n;
      overrun      <= overrun_n;
      drop_cnt     <= drop_cnt_n;
    end
  end

  qam_iq_reassembler #(
    .DOUT_W(DOUT_W)
  ) u_reasm (
    .axi_clk     (axi_clk),
    .axi_rst     (axi_rst),
    .fir_m_tvalid(fir_m_tvalid),
    .fir_m_tdata (fir_m_tdata),
    .outst_zero  (outst == '0),
    .m_valid     (m_valid),
    .m_i         (m_i),
    .m_q         (m_q),
    .orphan      (orphan)
  );

endmodule

// File: tb/tb_qam_defir_scheduler.sv
// Bench for qam_defir_scheduler: FIR behavioural model (y = sext(x) + 1, fixed latency),
// pair scoreboard, directed vector table and randomized traffic.
module tb_qam_defir_scheduler;

  localparam int unsigned DIN_W  = 24;
  localparam int unsigned DOUT_W = 32;
  localparam int unsigned CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              s_valid;
  logic              s_ready;
  logic [DIN_W-1:0]  s_i;
  logic [DIN_W-1:0]  s_q;
  logic              fir_s_tvalid;
  logic              fir_s_tready;
  logic [DIN_W-1:0]  fir_s_tdata;
  logic              fir_m_tvalid;
  logic [DOUT_W-1:0] fir_m_tdata;
  logic              m_valid;
  logic [DOUT_W-1:0] m_i;
  logic [DOUT_W-1:0] m_q;
  logic              overrun;
  logic [CNT_W-1:0]  drop_cnt;
  logic              orphan;

  always #5 clk = ~clk;

  qam_defir_scheduler #(
    .DIN_W(DIN_W), .DOUT_W(DOUT_W), .MAX_OUTST(32), .CNT_W(CNT_W)
  ) dut (
    .axi_clk(clk), .axi_rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_i(s_i), .s_q(s_q),
    .fir_s_tvalid(fir_s_tvalid), .fir_s_tready(fir_s_tready), .fir_s_tdata(fir_s_tdata),
    .fir_m_tvalid(fir_m_tvalid), .fir_m_tdata(fir_m_tdata),
    .m_valid(m_valid), .m_i(m_i), .m_q(m_q),
    .overrun(overrun), .drop_cnt(drop_cnt), .orphan(orphan)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] fir_f(input logic [23:0] x);
    return {{8{x[23]}}, x} + 32'd1;
  endfunction

  // ---------------- FIR behavioural model ----------------
  typedef struct { int due; logic [31:0] d; } fbeat_t;
  fbeat_t fq[$];
  int     cyc = 0;
  int     fir_lat = 20;
  bit     fir_stall = 1'b0;
  int     credit_given = 0;
  int     credit_used = 0;
  logic        mdl_v = 1'b0;
  logic [31:0] mdl_d = '0;
  logic        man_v = 1'b0;
  logic [31:0] man_d = '0;

  assign fir_m_tvalid = mdl_v | man_v;
  assign fir_m_tdata  = man_v ? man_d : mdl_d;

  // ---------------- scoreboard ----------------
  typedef struct { logic [31:0] i; logic [31:0] q; } pair_t;
  pair_t eq[$];
  int hs_cnt = 0;
  int acc_cnt = 0;
  int drop_exp = 0;
  int m_cnt = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      fq.delete();
      eq.delete();
      acc_cnt  <= 0;
      drop_exp <= 0;
    end else begin
      if (fir_s_tvalid && fir_s_tready) begin
        fq.push_back('{cyc + fir_lat, fir_f(fir_s_tdata)});
        hs_cnt <= hs_cnt + 1;
      end
      if (s_valid && s_ready) begin
        eq.push_back('{fir_f(s_i), fir_f(s_q)});
        acc_cnt <= acc_cnt + 1;
      end
      if (s_valid && !s_ready) drop_exp <= drop_exp + 1;
    end
  end

  always @(negedge clk) begin
    if (!rst && fq.size() > 0 && fq[0].due <= cyc &&
        (!fir_stall || credit_given > credit_used)) begin
      mdl_v <= 1'b1;
      mdl_d <= fq[0].d;
      void'(fq.pop_front());
      if (fir_stall) credit_used <= credit_used + 1;
    end else begin
      mdl_v <= 1'b0;
    end
  end

  // Every re-paired output must match the oldest accepted pair still owed.
  pair_t pexp;
  logic        pv = 1'b0;
  logic [23:0] pd = '0;
  always @(negedge clk) begin
    if (rst) begin
      m_cnt <= 0;
    end else if (m_valid) begin
      m_cnt <= m_cnt + 1;
      if (eq.size() == 0) begin
        chk("m_unexpected", {63'd0, m_valid}, 64'd0);
      end else begin
        pexp = eq.pop_front();
        chk("sb_m_i", 64'(m_i), 64'(pexp.i));
        chk("sb_m_q", 64'(m_q), 64'(pexp.q));
      end
    end
    if (!rst && pv) chk("beat_stable", {39'd0, fir_s_tvalid, fir_s_tdata}, {39'd0, 1'b1, pd});
    pv <= !rst && fir_s_tvalid && !fir_s_tready;
    pd <= fir_s_tdata;
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic send_pair(input logic [23:0] i, input logic [23:0] q);
    s_valid = 1'b1;
    s_i = i;
    s_q = q;
    tick(1);
    s_valid = 1'b0;
  endtask

  task automatic wait_m(input string nm, input logic [31:0] ei, input logic [31:0] eqv);
    bit seen = 1'b0;
    for (int k = 0; k < 80; k++) begin
      tick(1);
      if (m_valid) begin
        seen = 1'b1;
        break;
      end
    end
    chk({nm, "_seen"}, {63'd0, seen}, 64'd1);
    if (seen) begin
      chk({nm, "_m_i"}, 64'(m_i), 64'(ei));
      chk({nm, "_m_q"}, 64'(m_q), 64'(eqv));
      tick(1);
      chk({nm, "_pulse"}, {63'd0, m_valid}, 64'd0);
      tick(2);
      chk({nm, "_hold"}, {m_i, m_q}, {ei, eqv});
    end
  endtask

  task automatic drain(input string nm);
    for (int k = 0; k < 400; k++) begin
      if (eq.size() == 0 && fq.size() == 0 && s_ready) break;
      tick(1);
    end
    tick(3);
    chk({nm, "_drained"}, 64'(eq.size()), 64'd0);
  endtask

  typedef struct {
    logic [23:0] i;
    logic [23:0] q;
    logic [31:0] mi;
    logic [31:0] mq;
  } vec_t;
  vec_t tbl[4];

  initial begin
    int hs0, m0;
    tbl[0] = '{24'h000100, 24'hFFFF00, 32'h00000101, 32'hFFFFFF01};
    tbl[1] = '{24'h7FFFFF, 24'h800000, 32'h00800000, 32'hFF800001};
    tbl[2] = '{24'h000000, 24'hFFFFFF, 32'h00000001, 32'h00000000};
    tbl[3] = '{24'h123456, 24'hABCDEF, 32'h00123457, 32'hFFABCDF0};

    s_valid = 1'b0; s_i = '0; s_q = '0; fir_s_tready = 1'b1;
    do_reset();
    chk("rst_s_ready", {63'd0, s_ready}, 64'd1);
    chk("rst_tvalid", {63'd0, fir_s_tvalid}, 64'd0);
    chk("rst_m_valid", {63'd0, m_valid}, 64'd0);
    chk("rst_flags", {62'd0, overrun, orphan}, 64'd0);
    chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    chk("rst_data", {m_i, m_q}, 64'd0);

    // Directed table: serialisation timing and re-paired results.
    for (int v = 0; v < 4; v++) begin
      send_pair(tbl[v].i, tbl[v].q);
      chk("tbl_ready_low", {63'd0, s_ready}, 64'd0);
      chk("tbl_beat_i", {39'd0, fir_s_tvalid, fir_s_tdata}, {39'd0, 1'b1, tbl[v].i});
      tick(1);
      chk("tbl_beat_q", {39'd0, fir_s_tvalid, fir_s_tdata}, {39'd0, 1'b1, tbl[v].q});
      tick(1);
      chk("tbl_idle", {62'd0, fir_s_tvalid, s_ready}, 64'd1);
      wait_m("tbl", tbl[v].mi, tbl[v].mq);
    end

    // Backpressure in SEND_I with an overrunning pair.
    chk("bp_overrun_pre", {63'd0, overrun}, 64'd0);
    send_pair(24'h000ABC, 24'h000DEF);
    fir_s_tready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("bp_hold", {39'd0, fir_s_tvalid, fir_s_tdata}, {39'd0, 1'b1, 24'h000ABC});
      s_valid = (k == 2);
      s_i = 24'h555555;
      s_q = 24'h666666;
      tick(1);
    end
    s_valid = 1'b0;
    chk("bp_overrun", {63'd0, overrun}, 64'd1);
    chk("bp_drop_cnt", 64'(drop_cnt), 64'd1);
    fir_s_tready = 1'b1;
    wait_m("bp", 32'h00000ABD, 32'h00000DF0);
    chk("bp_drop_cnt_keep", 64'(drop_cnt), 64'd1);

    // Orphan beat after reset, then a normal pair must still pair up correctly.
    do_reset();
    chk("orph_rst_overrun", {63'd0, overrun}, 64'd0);
    man_v = 1'b1;
    man_d = 32'hDEADBEEF;
    tick(1);
    man_v = 1'b0;
    chk("orph_flag", {63'd0, orphan}, 64'd1);
    tick(2);
    chk("orph_no_m", {63'd0, m_valid}, 64'd0);
    send_pair(tbl[0].i, tbl[0].q);
    wait_m("orph", tbl[0].mi, tbl[0].mq);

    // Reset between the I and Q results.
    do_reset();
    chk("mid_orphan_clr", {63'd0, orphan}, 64'd0);
    send_pair(tbl[3].i, tbl[3].q);
    for (int k = 0; k < 60; k++) begin
      if (fir_m_tvalid) break;
      tick(1);
    end
    chk("mid_i_returned", {63'd0, fir_m_tvalid}, 64'd1);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (m_valid) chk("mid_no_m", {63'd0, m_valid}, 64'd0);
      tick(1);
    end
    send_pair(tbl[1].i, tbl[1].q);
    wait_m("mid", tbl[1].mi, tbl[1].mq);

    // Stall: FIR never returns, window fills at 32 beats; one result frees one beat.
    do_reset();
    fir_stall = 1'b1;
    m0 = m_cnt;
    for (int p = 0; p < 16; p++) begin
      send_pair(24'($urandom), 24'($urandom));
      tick(2);
    end
    chk("stall_idle", {62'd0, fir_s_tvalid, s_ready}, 64'd1);
    send_pair(24'h0C0FFE, 24'h0BEEF0);
    chk("stall_blocked", {62'd0, fir_s_tvalid, s_ready}, 64'd0);
    tick(3);
    chk("stall_still", 64'(fir_s_tvalid), 64'd0);
    hs0 = hs_cnt;
    credit_given = credit_given + 1;
    tick(10);
    chk("stall_one_beat", 64'(hs_cnt - hs0), 64'd1);
    chk("stall_in_q", {62'd0, fir_s_tvalid, s_ready}, 64'd0);
    fir_stall = 1'b0;
    drain("stall");
    chk("stall_m_count", 64'(m_cnt - m0), 64'd17);

    // Randomized traffic with random backpressure, FIR latency and FIR stalls.
    do_reset();
    for (int c = 0; c < 2500; c++) begin
      if (c % 250 == 0) fir_lat = 2 + int'($urandom_range(0, 24));
      s_valid = ($urandom_range(0, 2) == 0);
      s_i = 24'($urandom);
      s_q = 24'($urandom);
      fir_s_tready = ($urandom_range(0, 3) != 0);
      fir_stall = ($urandom_range(0, 15) == 0);
      tick(1);
    end
    s_valid = 1'b0;
    fir_s_tready = 1'b1;
    fir_stall = 1'b0;
    drain("rand");
    chk("rand_m_count", 64'(m_cnt), 64'(acc_cnt));
    chk("rand_drop_cnt", 64'(drop_cnt), 64'(drop_exp));
    chk("rand_overrun", {63'd0, overrun}, {63'd0, drop_exp != 0});
    chk("rand_orphan", {63'd0, orphan}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (vectors %0d, errors %0d)", n_vec, n_err);
    $fatal(1);
  end

endmodule
